// File: rtl/exc_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : exc_sequencer_if
// Purpose  : Bundle of decode-side inputs and CP0/PC-select outputs used by
//            the exception sequencer.
// Modports : master - decode/CP0 side (drives decode inputs, exc_addr)
//            slave  - exc_sequencer (drives strobes, stall, redirect, flush)
// Signals  : inst_valid, is_syscall, is_break, is_teq, is_eret, teq_a[31:0],
//            teq_b[31:0], pc[31:0], status[31:0], exc_addr[31:0] (to slave)
//            cause[3:0], teq_exc, eret, exc_pc[31:0], stall, pc_redirect,
//            redirect_addr[31:0], flush (from slave)
// Revision : 1.0 - initial release
// ============================================================================
interface exc_sequencer_if;
    logic        inst_valid;
    logic        is_syscall;
    logic        is_break;
    logic        is_teq;
    logic        is_eret;
    logic [31:0] teq_a;
    logic [31:0] teq_b;
    logic [31:0] pc;
    logic [31:0] status;
    logic [31:0] exc_addr;

    logic [3:0]  cause;
    logic        teq_exc;
    logic        eret;
    logic [31:0] exc_pc;
    logic        stall;
    logic        pc_redirect;
    logic [31:0] redirect_addr;
    logic        flush;

    modport master (
        output inst_valid, is_syscall, is_break, is_teq, is_eret,
               teq_a, teq_b, pc, status, exc_addr,
        input  cause, teq_exc, eret, exc_pc, stall, pc_redirect,
               redirect_addr, flush
    );

    modport slave (
        input  inst_valid, is_syscall, is_break, is_teq, is_eret,
               teq_a, teq_b, pc, status, exc_addr,
        output cause, teq_exc, eret, exc_pc, stall, pc_redirect,
               redirect_addr, flush
    );
endinterface
`default_nettype wire

// File: rtl/exc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : exc_sequencer
// Purpose  : Converts decoded trap instructions (syscall, break, teq, eret)
//            into single-cycle CP0 strobes, presents the faulting PC for the
//            epc write, then redirects fetch to CP0's exc_addr and flushes
//            IF/ID for FLUSH_CYCLES cycles.
// Ports    : clk  - system clock, rising edge
//            rst  - asynchronous active-high reset
//            bus  - exc_sequencer_if.slave (decode inputs, CP0/PC outputs)
// Sequence : IDLE --accept--> ISSUE (1) --> REDIRECT (1) --> DRAIN --> IDLE
// Revision : 1.0 - initial release
// ============================================================================
module exc_sequencer #(
    parameter int unsigned FLUSH_CYCLES = 2,        // legal range 1..15
    parameter logic [3:0]  SYSCALL_CODE = 4'b1000,
    parameter logic [3:0]  BREAK_CODE   = 4'b1001,
    parameter logic [3:0]  TEQ_CODE     = 4'b1101
) (
    input  wire logic      clk,
    input  wire logic      rst,
    exc_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_REDIRECT = 2'd2,
        S_DRAIN    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        K_SYSCALL = 2'd0,
        K_BREAK   = 2'd1,
        K_TEQ     = 2'd2,
        K_ERET    = 2'd3
    } kind_t;

    localparam logic [3:0] c_FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    kind_t       r_kind;
    kind_t       w_kind_sel;
    logic [3:0]  r_code;
    logic [3:0]  w_code_sel;
    logic [31:0] r_pc;
    logic [3:0]  r_cnt;
    logic        w_take;
    logic        w_accept;

    // Only status[3:0] carries enable bits relevant to this block.
    logic        w_unused_status;
    assign w_unused_status = ^bus.status[31:4];

    // Priority select: the highest-priority asserted is_* wins, then its own
    // enable condition decides whether it traps or degrades to a NOP.
    always_comb begin
        w_kind_sel = K_ERET;
        w_code_sel = 4'd0;
        w_take     = 1'b0;
        if (bus.is_eret) begin
            w_kind_sel = K_ERET;
            w_code_sel = 4'd0;
            w_take     = 1'b1;
        end else if (bus.is_syscall) begin
            w_kind_sel = K_SYSCALL;
            w_code_sel = SYSCALL_CODE;
            w_take     = bus.status[0] & bus.status[1];
        end else if (bus.is_break) begin
            w_kind_sel = K_BREAK;
            w_code_sel = BREAK_CODE;
            w_take     = bus.status[0] & bus.status[2];
        end else if (bus.is_teq) begin
            w_kind_sel = K_TEQ;
            w_code_sel = TEQ_CODE;
            w_take     = bus.status[0] & bus.status[3] & (bus.teq_a == bus.teq_b);
        end
    end

    // Gating with rst keeps the combinational stall low while reset is held.
    assign w_accept = ~rst & bus.inst_valid & w_take & (r_state == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kind <= K_SYSCALL;
            r_code <= 4'd0;
            r_pc   <= 32'd0;
        end else if (w_accept) begin
            r_kind <= w_kind_sel;
            r_code <= w_code_sel;
            r_pc   <= bus.pc;
        end
    end

    // Counter holds the number of DRAIN cycles still owed after REDIRECT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (r_state == S_REDIRECT) begin
            r_cnt <= c_FLUSH_LOAD;
        end else if ((r_state == S_DRAIN) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        bus.cause         = 4'd0;
        bus.teq_exc       = 1'b0;
        bus.eret          = 1'b0;
        bus.stall         = 1'b0;
        bus.pc_redirect   = 1'b0;
        bus.redirect_addr = 32'd0;
        bus.flush         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    bus.stall   = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus.cause   = r_code;
                bus.teq_exc = (r_kind == K_TEQ);
                bus.eret    = (r_kind == K_ERET);
                bus.stall   = 1'b1;
                w_state_nxt = S_REDIRECT;
            end
            S_REDIRECT: begin
                bus.pc_redirect   = 1'b1;
                bus.redirect_addr = bus.exc_addr;
                bus.stall         = 1'b1;
                bus.flush         = 1'b1;
                w_state_nxt       = (FLUSH_CYCLES <= 1) ? S_IDLE : S_DRAIN;
            end
            S_DRAIN: begin
                bus.flush = 1'b1;
                // Leave on the edge where the decremented count reaches zero,
                // so REDIRECT plus DRAIN gives exactly FLUSH_CYCLES flush cycles.
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.exc_pc = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_exc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_exc_sequencer
// Purpose  : Self-checking bench for exc_sequencer: directed scenarios plus
//            randomized traffic against a timeline-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exc_sequencer;

    localparam int F = 2;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    exc_sequencer_if bus ();

    exc_sequencer #(
        .FLUSH_CYCLES (F),
        .SYSCALL_CODE (4'b1000),
        .BREAK_CODE   (4'b1001),
        .TEQ_CODE     (4'b1101)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {cause[3:0], teq_exc, eret, stall, pc_redirect, flush}
    logic [8:0] ctl;
    assign ctl = {bus.cause, bus.teq_exc, bus.eret, bus.stall, bus.pc_redirect, bus.flush};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        bus.inst_valid = 1'b0;
        bus.is_syscall = 1'b0;
        bus.is_break   = 1'b0;
        bus.is_teq     = 1'b0;
        bus.is_eret    = 1'b0;
        bus.teq_a      = 32'd0;
        bus.teq_b      = 32'd0;
        bus.pc         = 32'd0;
        bus.status     = 32'd0;
        bus.exc_addr   = 32'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        @(negedge clk); #1;
        n_cmp++;
        if (ctl !== 9'd0 || bus.exc_pc !== 32'd0 || bus.redirect_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_hold ctl=%h exc_pc=%h redir=%h required all 0", ctl, bus.exc_pc, bus.redirect_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (ctl !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_release ctl=%h required 0", ctl);
        end
        // Reset asserted in the middle of ISSUE
        @(negedge clk);
        bus.inst_valid = 1'b1; bus.is_syscall = 1'b1; bus.status = 32'h3;
        bus.pc = 32'h0040_0100; bus.exc_addr = 32'h4;
        @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++;
        if (ctl !== {4'd8, 5'b00100}) begin
            n_fail++;
            $display("FAIL rst_pre_issue ctl=%h required %h", ctl, {4'd8, 5'b00100});
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (ctl !== 9'd0 || bus.exc_pc !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_async ctl=%h exc_pc=%h required 0/0", ctl, bus.exc_pc);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (ctl !== 9'd0) begin
                n_fail++;
                $display("FAIL rst_after[%0d] ctl=%h required 0", i, ctl);
            end
        end
    endtask

    task automatic test_syscall();
        @(negedge clk);
        bus.inst_valid = 1'b1; bus.is_syscall = 1'b1; bus.status = 32'h3;
        bus.pc = 32'h0040_0010; bus.exc_addr = 32'h0000_0004;
        #1;
        n_cmp++;
        if (ctl !== {4'd0, 5'b00100}) begin
            n_fail++;
            $display("FAIL sys_accept ctl=%h required %h", ctl, {4'd0, 5'b00100});
        end
        @(negedge clk);
        clear_inputs(); bus.exc_addr = 32'h0000_0004;
        #1;
        n_cmp++;
        if (ctl !== {4'd8, 5'b00100} || bus.exc_pc !== 32'h0040_0010) begin
            n_fail++;
            $display("FAIL sys_issue ctl=%h exc_pc=%h required %h/00400010", ctl, bus.exc_pc, {4'd8, 5'b00100});
        end
        @(negedge clk); #1;
        n_cmp++;
        if (ctl !== {4'd0, 5'b00111} || bus.redirect_addr !== 32'h4) begin
            n_fail++;
            $display("FAIL sys_redirect ctl=%h redir=%h required %h/4", ctl, bus.redirect_addr, {4'd0, 5'b00111});
        end
        @(negedge clk); #1;
        n_cmp++;
        if (ctl !== {4'd0, 5'b00001}) begin
            n_fail++;
            $display("FAIL sys_drain ctl=%h required %h", ctl, {4'd0, 5'b00001});
        end
        @(negedge clk); #1;
        n_cmp++;
        if (ctl !== 9'd0 || bus.exc_pc !== 32'h0040_0010 || bus.redirect_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL sys_idle ctl=%h exc_pc=%h redir=%h required 0/00400010/0", ctl, bus.exc_pc, bus.redirect_addr);
        end
    endtask

    task automatic test_teq();
        @(negedge clk);
        bus.inst_valid = 1'b1; bus.is_teq = 1'b1; bus.status = 32'h9;
        bus.teq_a = 32'h1234_5678; bus.teq_b = 32'h1234_5678; bus.pc = 32'h0040_0200;
        #1;
        n_cmp++;
        if (ctl !== {4'd0, 5'b00100}) begin
            n_fail++;
            $display("FAIL teq_accept ctl=%h required %h", ctl, {4'd0, 5'b00100});
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++;
        if (ctl !== {4'd13, 5'b10100} || bus.exc_pc !== 32'h0040_0200) begin
            n_fail++;
            $display("FAIL teq_issue ctl=%h exc_pc=%h required %h/00400200", ctl, bus.exc_pc, {4'd13, 5'b10100});
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        bus.inst_valid = 1'b1; bus.is_teq = 1'b1; bus.status = 32'h9;
        bus.teq_a = 32'h1; bus.teq_b = 32'h2;
        #1;
        n_cmp++;
        if (ctl !== 9'd0) begin
            n_fail++;
            $display("FAIL teq_ne_accept ctl=%h required 0", ctl);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++;
        if (ctl !== 9'd0) begin
            n_fail++;
            $display("FAIL teq_ne_after ctl=%h required 0", ctl);
        end
    endtask

    task automatic test_masked();
        @(negedge clk);
        bus.inst_valid = 1'b1; bus.is_syscall = 1'b1; bus.status = 32'h1;
        #1;
        n_cmp++;
        if (ctl !== 9'd0) begin
            n_fail++;
            $display("FAIL masked_accept ctl=%h required 0", ctl);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++;
        if (ctl !== 9'd0) begin
            n_fail++;
            $display("FAIL masked_after ctl=%h required 0", ctl);
        end
    endtask

    task automatic test_eret();
        @(negedge clk);
        bus.inst_valid = 1'b1; bus.is_eret = 1'b1; bus.status = 32'h0;
        bus.pc = 32'h0040_0300; bus.exc_addr = 32'h0040_0010;
        #1;
        n_cmp++;
        if (ctl !== {4'd0, 5'b00100}) begin
            n_fail++;
            $display("FAIL eret_accept ctl=%h required %h", ctl, {4'd0, 5'b00100});
        end
        @(negedge clk);
        clear_inputs(); bus.exc_addr = 32'h0040_0010;
        #1;
        n_cmp++;
        if (ctl !== {4'd0, 5'b01100}) begin
            n_fail++;
            $display("FAIL eret_issue ctl=%h required %h", ctl, {4'd0, 5'b01100});
        end
        @(negedge clk); #1;
        n_cmp++;
        if (ctl !== {4'd0, 5'b00111} || bus.redirect_addr !== 32'h0040_0010) begin
            n_fail++;
            $display("FAIL eret_redirect ctl=%h redir=%h required %h/00400010", ctl, bus.redirect_addr, {4'd0, 5'b00111});
        end
        @(negedge clk); #1;
        @(negedge clk); #1;
        n_cmp++;
        if (ctl !== 9'd0) begin
            n_fail++;
            $display("FAIL eret_idle ctl=%h required 0", ctl);
        end
    endtask

    task automatic test_priority_drain();
        @(negedge clk);
        bus.inst_valid = 1'b1; bus.is_syscall = 1'b1; bus.is_break = 1'b1;
        bus.status = 32'h7; bus.pc = 32'h0040_0400;
        @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++;
        if (ctl !== {4'd8, 5'b00100}) begin
            n_fail++;
            $display("FAIL prio_issue ctl=%h required %h", ctl, {4'd8, 5'b00100});
        end
        @(negedge clk);
        @(negedge clk);
        // DRAIN cycle: a syscall here must be ignored
        bus.inst_valid = 1'b1; bus.is_syscall = 1'b1; bus.status = 32'h3;
        #1;
        n_cmp++;
        if (ctl !== {4'd0, 5'b00001}) begin
            n_fail++;
            $display("FAIL drain_ignore ctl=%h required %h", ctl, {4'd0, 5'b00001});
        end
        @(negedge clk);
        clear_inputs();
        #1;
        n_cmp++;
        if (ctl !== 9'd0) begin
            n_fail++;
            $display("FAIL drain_no_issue ctl=%h required 0", ctl);
        end
    endtask

    // Reference model: an accepted trap at cycle t fixes a timeline
    // (t: stall, t+1: strobes, t+2: redirect, t+2..t+F+1: flush).
    task automatic test_random();
        int          acc;
        bit          acc_v;
        int          d;
        logic [31:0] m_epc, acc_pc;
        logic [3:0]  acc_code, code;
        bit          acc_teq, acc_eret, take, k_teq, k_eret;
        logic [8:0]  e_ctl;
        logic [31:0] e_redir;
        logic [31:0] st, a, b, p, ea;
        bit          v, sy, br, tq, er;

        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        acc = 0; acc_v = 0; m_epc = 32'd0; acc_pc = 32'd0; acc_code = 4'd0;
        acc_teq = 0; acc_eret = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 99) == 0);
            v  = ($urandom_range(0, 3) != 0);
            sy = ($urandom_range(0, 2) == 0);
            br = ($urandom_range(0, 2) == 0);
            tq = ($urandom_range(0, 2) == 0);
            er = ($urandom_range(0, 5) == 0);
            st = $urandom;
            if ($urandom_range(0, 3) != 0) st[0] = 1'b1;
            a  = $urandom;
            b  = ($urandom_range(0, 1) == 0) ? a : $urandom;
            p  = $urandom;
            ea = $urandom;
            bus.inst_valid = v; bus.is_syscall = sy; bus.is_break = br;
            bus.is_teq = tq; bus.is_eret = er; bus.status = st;
            bus.teq_a = a; bus.teq_b = b; bus.pc = p; bus.exc_addr = ea;
            #1;
            e_ctl = 9'd0;
            e_redir = 32'd0;
            if (rst) begin
                acc_v = 0;
                m_epc = 32'd0;
            end else begin
                d = cyc - acc;
                if (acc_v && d == 1) m_epc = acc_pc;
                if (acc_v && d >= 1 && d <= F + 1) begin
                    if (d == 1)      e_ctl = {acc_code, acc_teq, acc_eret, 3'b100};
                    else if (d == 2) begin e_ctl = {4'd0, 5'b00111}; e_redir = ea; end
                    else             e_ctl = {4'd0, 5'b00001};
                end else begin
                    take = 0; code = 4'd0; k_teq = 0; k_eret = 0;
                    if (er)      begin take = 1; k_eret = 1; end
                    else if (sy) begin take = st[0] && st[1]; code = 4'd8; end
                    else if (br) begin take = st[0] && st[2]; code = 4'd9; end
                    else if (tq) begin take = st[0] && st[3] && (a == b); code = 4'd13; k_teq = 1; end
                    if (v && take) begin
                        acc = cyc; acc_v = 1; acc_pc = p; acc_code = code;
                        acc_teq = k_teq; acc_eret = k_eret;
                        e_ctl = {4'd0, 5'b00100};
                    end
                end
            end
            n_cmp++;
            if (ctl !== e_ctl) begin
                n_fail++;
                $display("FAIL rnd_ctl cyc=%0d ctl=%h required %h", cyc, ctl, e_ctl);
            end
            n_cmp++;
            if (bus.exc_pc !== m_epc) begin
                n_fail++;
                $display("FAIL rnd_exc_pc cyc=%0d exc_pc=%h required %h", cyc, bus.exc_pc, m_epc);
            end
            n_cmp++;
            if (bus.redirect_addr !== e_redir) begin
                n_fail++;
                $display("FAIL rnd_redirect cyc=%0d redir=%h required %h", cyc, bus.redirect_addr, e_redir);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        clear_inputs();
        test_reset();
        test_syscall();
        test_teq();
        test_masked();
        test_eret();
        test_priority_drain();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
